// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit with sub-word merge and extension over a
// 4 KB word memory
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] address,
    output logic [31:0] data_in,
    input  logic [31:0] data_out,
    output logic        we
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    state_t      state_q, state_d;
    logic        op_we_q, op_we_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        err_q, err_d;
    logic [31:0] address_q, address_d;
    logic [31:0] data_in_q, data_in_d;
    logic [31:0] rdata_q, rdata_d;
    logic        acc_err;
    logic [4:0]  sh;
    logic [31:0] shifted, mask, merged, load_ext;
    assign acc_err = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00) || (req_addr[31:12] != 20'd0);
    assign sh       = {lane_q, 3'b000};
    assign shifted  = data_out >> sh;
    assign mask     = (size_q == 2'b00) ? (32'h0000_00FF << sh) : (32'h0000_FFFF << sh);
    assign merged   = (data_out & ~mask) | ((wdata_q << sh) & mask);
    assign load_ext = (size_q == 2'b00) ? {{24{~uns_q & shifted[7]}}, shifted[7:0]} :
                      (size_q == 2'b01) ? {{16{~uns_q & shifted[15]}}, shifted[15:0]} : data_out;
    always_comb begin
        state_d   = state_q;
        op_we_d   = op_we_q;
        lane_d    = lane_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        uns_d     = uns_q;
        err_d     = err_q;
        address_d = address_q;
        data_in_d = data_in_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: if (req_valid) begin
                op_we_d   = req_we;
                lane_d    = req_addr[1:0];
                wdata_d   = req_wdata;
                size_d    = req_size;
                uns_d     = req_unsigned;
                err_d     = acc_err;
                address_d = {req_addr[31:2], 2'b00};
                data_in_d = req_wdata;
                rdata_d   = 32'd0;
                state_d   = acc_err ? RESP : (req_we && req_size == 2'b10) ? WR : RD;
            end
            RD: begin
                data_in_d = op_we_q ? merged : data_in_q;
                rdata_d   = op_we_q ? 32'd0 : load_ext;
                state_d   = op_we_q ? WR : RESP;
            end
            WR:      state_d = RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_we_q   <= 1'b0;
            lane_q    <= 2'b00;
            wdata_q   <= 32'd0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            address_q <= 32'd0;
            data_in_q <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            op_we_q   <= op_we_d;
            lane_q    <= lane_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            err_q     <= err_d;
            address_q <= address_d;
            data_in_q <= data_in_d;
            rdata_q   <= rdata_d;
        end
    end
    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == RESP;
    assign rsp_error = rsp_valid & err_q;
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign we        = state_q == WR;
    assign address   = address_q;
    assign data_in   = data_in_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed requests against a 4 KB memory model; a scoreboard queue holds the
// expected responses and a negedge monitor checks them, with latencies measured from acceptance.
module tb_mem_access_unit;
    logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic        req_ready, rsp_valid, rsp_error, we;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0, rsp_rdata, address, data_in, data_out;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] mem [0:1023];
    typedef struct {logic [31:0] rdata; logic err; int lat;} exp_t;
    exp_t exp_q[$];
    int   acc_q[$], acc_hist[$];
    int   checks = 0, errors = 0, ncyc = 0, we_cnt = 0, we0;
    mem_access_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .address(address),
        .data_in(data_in), .data_out(data_out), .we(we)
    );
    always #5 clk = ~clk;
    assign data_out = mem[address[11:2]];
    always @(posedge clk) if (we) mem[address[11:2]] <= data_in;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // Monitor: log acceptances, count write cycles, score responses.
    always @(negedge clk) begin
        exp_t e;
        int   a;
        ncyc++;
        if (we) we_cnt++;
        if (req_valid && req_ready && !reset) begin
            acc_q.push_back(ncyc);
            acc_hist.push_back(ncyc);
        end
        if (rsp_valid) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
                chk("latency", ncyc - a, e.lat);
            end
        end else if (rsp_error || rsp_rdata != 32'd0) begin
            chk("idle_rsp_zero", {rsp_rdata[30:0], rsp_error}, 32'd0);
        end
    end
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                        input logic u, input logic [31:0] er, input logic ee, input int lat, input bit hold);
        bit got = 0;
        if (lat > 0) exp_q.push_back('{er, ee, lat});
        req_we = w; req_addr = a; req_wdata = d; req_size = s; req_unsigned = u; req_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
        end
        if (!got) begin
            chk("accept_timeout", 32'd0, 32'd1);
            if (lat > 0) void'(exp_q.pop_back());
        end
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
    endtask
    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        chk("drain", exp_q.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[10'h200] = 32'h8899AABB;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_address", address, 32'd0);
        chk("rst_data_in", data_in, 32'd0);
        @(posedge clk); #1;
        send(0, 32'h801, 0, 2'b00, 0, 32'hFFFFFFAA, 0, 2, 0);
        send(0, 32'h801, 0, 2'b00, 1, 32'h000000AA, 0, 2, 0);
        drain();
        we0 = we_cnt;
        send(1, 32'h802, 32'h1234, 2'b01, 0, 32'd0, 0, 3, 0);
        drain();
        chk("half_store_we", we_cnt - we0, 32'd1);
        chk("half_store_mem", mem[10'h200], 32'h1234AABB);
        send(0, 32'h802, 0, 2'b01, 0, 32'h00001234, 0, 2, 0);
        send(1, 32'h803, 32'hFFEE, 2'b00, 0, 32'd0, 0, 3, 0);
        send(0, 32'h800, 0, 2'b10, 0, 32'hEE34AABB, 0, 2, 0);
        send(0, 32'h800, 0, 2'b01, 0, 32'hFFFFAABB, 0, 2, 0);
        send(0, 32'h803, 0, 2'b00, 1, 32'h000000EE, 0, 2, 0);
        drain();
        chk("byte_store_mem", mem[10'h200], 32'hEE34AABB);
        we0 = we_cnt;
        send(0, 32'h803, 0, 2'b10, 0, 32'd0, 1, 1, 0);
        send(0, 32'h1000, 0, 2'b10, 0, 32'd0, 1, 1, 0);
        send(0, 32'h801, 0, 2'b01, 0, 32'd0, 1, 1, 0);
        send(1, 32'h800, 32'h5, 2'b11, 0, 32'd0, 1, 1, 0);
        send(1, 32'h802, 32'h5, 2'b10, 0, 32'd0, 1, 1, 0);
        drain();
        chk("error_no_we", we_cnt - we0, 32'd0);
        chk("error_mem", mem[10'h200], 32'hEE34AABB);
        we0 = we_cnt;
        send(1, 32'h800, 32'h55, 2'b00, 0, 32'd0, 0, -1, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        acc_q.delete();
        @(negedge clk);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_we", we_cnt - we0, 32'd0);
        chk("abort_mem", mem[10'h200], 32'hEE34AABB);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h800; req_size = 2'b10; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("rst_override_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_override_acc", acc_q.size(), 32'd0);
        @(posedge clk); #1;
        we0 = we_cnt;
        send(1, 32'h804, 32'h11111111, 2'b10, 0, 32'd0, 0, 2, 1);
        send(1, 32'h804, 32'h22222222, 2'b10, 0, 32'd0, 0, 2, 0);
        drain();
        chk("held_we", we_cnt - we0, 32'd2);
        chk("held_mem", mem[10'h201], 32'h22222222);
        chk("held_gap", acc_hist[acc_hist.size()-1] - acc_hist[acc_hist.size()-2], 32'd3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have no parameters; data and address widths are fixed at 32 bits.
REQ-002 SHALL use one clock and one reset: reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  core presents a load/store request.
REQ-006 req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-011 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-012 rsp_valid  output  1  one-cycle completion pulse.
REQ-013 rsp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-014 rsp_error  output  1  valid with rsp_valid: misaligned, out-of-range or reserved size.
REQ-015 address  output  32  to memory; word-aligned (bits [1:0] = 0), driven from a register.
REQ-016 data_in  output  32  to memory; merged write word, driven from a register.
REQ-017 data_out  input  32  from memory; combinational read of the word at address.
REQ-018 we  output  1  to memory; level write enable.

Function
REQ-019 SHALL implement the states IDLE, RD, WR and RESP.
REQ-020 IDLE: req_ready = 1; on req_valid, SHALL latch all req_* signals.
REQ-021 IDLE transitions on acceptance: error -> RESP; word store -> WR; all other requests -> RD.
REQ-022 An error SHALL be any of: req_size = 11; half with addr[0] = 1; word with addr[1:0] != 0; addr[31:12] != 0 (memory is 4 KB).
REQ-023 RD: address = {addr[31:2], 2'b00}, we = 0; SHALL capture data_out into a word register at the clock edge.
REQ-024 RD transitions: load -> RESP; byte or half store -> WR.
REQ-025 Store merge: SHALL replace the selected byte lane (addr[1:0]) or half lane (addr[1]) of the captured word with req_wdata; all other lanes are preserved; word store uses req_wdata unchanged.
REQ-026 WR: we = 1 for exactly one cycle, with address and data_in stable for the whole cycle; then -> RESP.
REQ-027 we SHALL be 0 in every state other than WR and SHALL be glitch-free (decoded from a registered state).
REQ-028 RESP: rsp_valid = 1 for one cycle, then -> IDLE; the response has no backpressure.
REQ-029 Load data: SHALL select the byte or half lane by addr[1:0], then extend per req_unsigned to 32 bits.
REQ-030 req_ready SHALL be 0 in RD, WR and RESP; req_valid in those states SHALL be ignored; a held request is accepted in the first IDLE cycle after RESP.
REQ-031 Latency, counted from the acceptance edge to the rsp_valid cycle:
- error: 1 cycle
- load or word store: 2 cycles
- byte/half store: 3 cycles
REQ-032 On an error, the unit SHALL NOT assert we and SHALL NOT rely on memory contents.
REQ-033 Outside RESP, rsp_rdata and rsp_error SHALL be 0.

Reset
REQ-034 On reset at a clock edge the unit SHALL go to IDLE; next cycle: req_ready = 1, rsp_valid = 0, rsp_error = 0, rsp_rdata = 0, we = 0, address = 0, data_in = 0.
REQ-035 Reset in RD or WR SHALL abort the access: no further we, no rsp_valid, memory untouched if reset precedes WR.
REQ-036 Reset SHALL override a simultaneous req_valid; that request is not accepted.

Verification (memory word 0x800 preset to 0x8899AABB)
REQ-037 Signed byte load at 0x801 -> rsp_rdata = 0xFFFFFFAA, rsp_error = 0, rsp_valid 2 cycles after acceptance; repeated unsigned -> 0x000000AA.
REQ-038 Half store of 0x1234 at 0x802 -> we high exactly 1 cycle, word 0x800 = 0x1234AABB, rsp_valid 3 cycles after acceptance.
REQ-039 Word load at 0x803, and word load at 0x1000 -> rsp_error = 1, rsp_rdata = 0, we never high, rsp_valid 1 cycle after acceptance.
REQ-040 Byte store at 0x800 with reset asserted during RD -> we never high, word 0x800 unchanged, no rsp_valid, req_ready = 1 the cycle after reset.
REQ-041 req_valid held high across two word stores, 0x11111111 then 0x22222222 at 0x804 -> second accepted only after the first RESP, we high in 2 separate cycles, final word 0x804 = 0x22222222.
